// File: rtl/cpu_seq_pkg.sv
// Shared types and default constants for the CPU run sequencer.
// Default parameter values used by cpu_run_sequencer and run_timer.
package cpu_seq_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETTLE,
      START,
      WAIT,
      REPORT
   } seqState_t;

   localparam int DEF_CNT_W         = 16;
   localparam int DEF_TIMEOUT       = 1000;
   localparam int DEF_SETTLE_CYCLES = 2;

endpackage

// File: rtl/cpu_run_sequencer_run_timer.sv
// Shared up-counter used for both the SETTLE countdown and the WAIT cycle count.
// hit flags the last cycle of the selected window (count == limit - 1).
module run_timer
   import cpu_seq_pkg::*;
#(
   parameter int CNT_W      = DEF_CNT_W,
   parameter int SETTLE_LIM = DEF_SETTLE_CYCLES,
   parameter int WAIT_LIM   = DEF_TIMEOUT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic             useWait,
   output logic [CNT_W-1:0] count,
   output logic             hit
);

   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_LIM - 1);
   localparam logic [CNT_W-1:0] WAIT_LAST   = CNT_W'(WAIT_LIM - 1);

   // NOTE: sequential state is assigned with <= so every flop samples the pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en) begin
         count <= count + CNT_W'(1);
      end
   end

   assign hit = useWait ? (count == WAIT_LAST) : (count == SETTLE_LAST);

endmodule

// File: rtl/cpu_run_sequencer.sv
// Host-side run controller: releases the CPU from reset, pulses start, times
// the run until done or timeout, and reports cycles/timed_out/runs to the host.
module cpu_run_sequencer
   import cpu_seq_pkg::*;
#(
   parameter int CNT_W         = DEF_CNT_W,
   parameter int TIMEOUT       = DEF_TIMEOUT,
   parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req,
   input  logic             abort,
   output logic             ack,
   output logic             busy,
   output logic             cpu_rst,
   output logic             cpu_start,
   input  logic             cpu_done,
   output logic             result_valid,
   output logic             timed_out,
   output logic [CNT_W-1:0] cycles,
   output logic [7:0]       runs
);

   seqState_t        state;
   seqState_t        nextState;
   logic             timerClr;
   logic             timerEn;
   logic             timerUseWait;
   logic             timerHit;
   logic [CNT_W-1:0] timerCount;
   logic             reportNow;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      nextState = state;
      unique case (state)
         IDLE:    if (req) nextState = SETTLE;
         SETTLE: begin
            if (abort)         nextState = IDLE;
            else if (timerHit) nextState = START;
         end
         START:   nextState = abort ? IDLE : WAIT;
         WAIT: begin
            // abort outranks done; done and timeout both end the run
            if (abort)                     nextState = IDLE;
            else if (cpu_done || timerHit) nextState = REPORT;
         end
         REPORT:  nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   assign timerClr     = (state != SETTLE) && (state != WAIT);
   assign timerEn      = !timerClr;
   assign timerUseWait = (state == WAIT);
   assign reportNow    = (state == WAIT) && (nextState == REPORT);

   run_timer #(
      .CNT_W      (CNT_W),
      .SETTLE_LIM (SETTLE_CYCLES),
      .WAIT_LIM   (TIMEOUT)
   ) uTimer (
      .clk     (clk),
      .rst     (rst),
      .clr     (timerClr),
      .en      (timerEn),
      .useWait (timerUseWait),
      .count   (timerCount),
      .hit     (timerHit)
   );

   // Outputs are decoded from nextState so they are registered yet aligned with state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cpu_rst      <= 1'b1;
         cpu_start    <= 1'b0;
         ack          <= 1'b0;
         busy         <= 1'b0;
         result_valid <= 1'b0;
         timed_out    <= 1'b0;
         cycles       <= '0;
         runs         <= '0;
      end else begin
         cpu_rst      <= (nextState == IDLE) || (nextState == REPORT);
         cpu_start    <= (nextState == START);
         ack          <= (state == IDLE) && (nextState == SETTLE);
         busy         <= (nextState == SETTLE) || (nextState == START) || (nextState == WAIT);
         result_valid <= (nextState == REPORT);
         if (reportNow) begin
            cycles    <= timerCount + CNT_W'(1);
            timed_out <= !cpu_done;
            runs      <= runs + 8'd1;
         end
      end
   end

endmodule
